// File: rtl/sprite_pkg.sv
// sprite_pkg: shared default widths, sequencer states and packed-slice helper for sprite_position_engine
package sprite_pkg;
    localparam int COORD_W_DEF = 9;
    localparam int STEP_W_DEF  = 5;

    typedef enum logic [1:0] {IDLE, EMIT, DONE} seq_state_e;

    function automatic int slice_lsb(input int idx, input int w);
        return idx * w;
    endfunction
endpackage

// File: rtl/axis_counter.sv
// axis_counter: one saturating coordinate register with clamped load
module axis_counter
    import sprite_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF,
    parameter int STEP_W  = STEP_W_DEF,
    parameter int LO      = 72,
    parameter int HI      = 232
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               load_i,
    input  logic [COORD_W-1:0] start_i,
    input  logic               move_i,
    input  logic               dir_i,
    input  logic [STEP_W-1:0]  speed_i,
    output logic [COORD_W-1:0] pos_o
);
    localparam int W1 = COORD_W + 1;
    localparam logic [W1-1:0] LO_E = W1'(LO);
    localparam logic [W1-1:0] HI_E = W1'(HI);

    logic [COORD_W-1:0] pos_q, pos_d;
    logic [W1-1:0]      pos_e, spd_e, start_e, inc_v, dec_v, load_v;

    // step and load are evaluated one bit wider so neither direction can wrap before saturating
    always_comb begin
        pos_e   = {1'b0, pos_q};
        spd_e   = W1'(speed_i);
        start_e = {1'b0, start_i};
        inc_v   = (pos_e + spd_e > HI_E) ? HI_E : pos_e + spd_e;
        dec_v   = (pos_e < LO_E + spd_e) ? LO_E : pos_e - spd_e;
        load_v  = (start_e < LO_E) ? LO_E : (start_e > HI_E) ? HI_E : start_e;
        pos_d   = load_i ? COORD_W'(load_v) : move_i ? COORD_W'(dir_i ? inc_v : dec_v) : pos_q;
    end

    // position register; reset parks the sprite on the low bound
    always_ff @(posedge clock) begin
        if (reset) pos_q <= COORD_W'(LO);
        else       pos_q <= pos_d;
    end

    assign pos_o = pos_q;
endmodule

// File: rtl/sprite_position_engine.sv
// sprite_position_engine: per-player saturating positions on a divided tick plus a snapshot/emit sequencer
// Optional grid-aligned movement is enabled by defining GRID_ALIGN_EN.
module sprite_position_engine
    import sprite_pkg::*;
#(
    parameter int N_PLAYERS = 2,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int STEP_W    = STEP_W_DEF,
    parameter int MIN_X     = 72,
    parameter int MAX_X     = 232,
    parameter int MIN_Y     = 32,
    parameter int MAX_Y     = 192,
    parameter int MOVE_DIV  = 833333,
    parameter int TILE_LOG2 = 4,
    localparam int ID_W     = (N_PLAYERS > 1) ? $clog2(N_PLAYERS) : 1
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           player_reset,
    input  logic [N_PLAYERS*COORD_W-1:0]   start_x,
    input  logic [N_PLAYERS*COORD_W-1:0]   start_y,
    input  logic [N_PLAYERS*STEP_W-1:0]    speed,
    input  logic [N_PLAYERS-1:0]           mov_x,
    input  logic [N_PLAYERS-1:0]           dir_x,
    input  logic [N_PLAYERS-1:0]           mov_y,
    input  logic [N_PLAYERS-1:0]           dir_y,
    output logic [N_PLAYERS*COORD_W-1:0]   live_x,
    output logic [N_PLAYERS*COORD_W-1:0]   live_y,
    input  logic                           draw_req,
    output logic                           pos_valid,
    output logic [ID_W-1:0]                pos_id,
    output logic [COORD_W-1:0]             pos_x,
    output logic [COORD_W-1:0]             pos_y,
    input  logic                           pos_ack,
    output logic                           busy,
    output logic                           done
);
`ifdef GRID_ALIGN_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif
    localparam int CNT_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam int TW    = (TILE_LOG2 > 0) ? TILE_LOG2 : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick;

    // free-running movement divider; tick marks the last count of each period
    always_comb begin
        tick  = (cnt_q == CNT_W'(MOVE_DIV - 1));
        cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end

    // divider register
    always_ff @(posedge clock) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    for (genvar i = 0; i < N_PLAYERS; i++) begin : g_player
        localparam int CL = slice_lsb(i, COORD_W);
        localparam int SL = slice_lsb(i, STEP_W);
        logic [COORD_W-1:0] px, py;
        logic               x_ok, y_ok, mx, my;
        // with grid alignment an axis may only move while the other axis sits on a tile line
        assign x_ok = !GRID || TILE_LOG2 == 0 || TW'(py - COORD_W'(MIN_Y)) == '0;
        assign y_ok = !GRID || TILE_LOG2 == 0 || TW'(px - COORD_W'(MIN_X)) == '0;
        assign mx   = tick && mov_x[i] && x_ok;
        assign my   = tick && mov_y[i] && y_ok && !(GRID && mx);
        axis_counter #(.COORD_W(COORD_W), .STEP_W(STEP_W), .LO(MIN_X), .HI(MAX_X)) u_x (
            .clock   (clock),
            .reset   (reset),
            .load_i  (player_reset),
            .start_i (start_x[CL +: COORD_W]),
            .move_i  (mx),
            .dir_i   (dir_x[i]),
            .speed_i (speed[SL +: STEP_W]),
            .pos_o   (px)
        );
        axis_counter #(.COORD_W(COORD_W), .STEP_W(STEP_W), .LO(MIN_Y), .HI(MAX_Y)) u_y (
            .clock   (clock),
            .reset   (reset),
            .load_i  (player_reset),
            .start_i (start_y[CL +: COORD_W]),
            .move_i  (my),
            .dir_i   (dir_y[i]),
            .speed_i (speed[SL +: STEP_W]),
            .pos_o   (py)
        );
        assign live_x[CL +: COORD_W] = px;
        assign live_y[CL +: COORD_W] = py;
    end

    seq_state_e                   state_q;
    logic [N_PLAYERS*COORD_W-1:0] snap_x_q, snap_y_q;
    logic [ID_W-1:0]              id_q, nid;
    logic [COORD_W-1:0]           px_q, py_q;
    logic                         valid_q, busy_q, done_q, last;

    assign last = (id_q == ID_W'(N_PLAYERS - 1));
    assign nid  = id_q + ID_W'(1);

    // snapshot on draw_req, then present one player per accept from the frozen copy
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            snap_x_q <= '0;
            snap_y_q <= '0;
            id_q     <= '0;
            px_q     <= '0;
            py_q     <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (draw_req) begin
                    snap_x_q <= live_x;
                    snap_y_q <= live_y;
                    id_q     <= '0;
                    px_q     <= live_x[COORD_W-1:0];
                    py_q     <= live_y[COORD_W-1:0];
                    valid_q  <= 1'b1;
                    busy_q   <= 1'b1;
                    state_q  <= EMIT;
                end
                EMIT: if (pos_ack) begin
                    if (last) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        id_q <= nid;
                        px_q <= snap_x_q[slice_lsb(int'(nid), COORD_W) +: COORD_W];
                        py_q <= snap_y_q[slice_lsb(int'(nid), COORD_W) +: COORD_W];
                    end
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign pos_valid = valid_q;
    assign pos_id    = id_q;
    assign pos_x     = px_q;
    assign pos_y     = py_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_sprite_position_engine.sv
// tb_sprite_position_engine: randomized self-checking bench with a behavioural position model
module tb_sprite_position_engine;
    localparam int NP = 2, CW = 9, SW = 5;
    localparam int MIN_X = 72, MAX_X = 232, MIN_Y = 32, MAX_Y = 192, TILE = 16;
`ifdef GRID_ALIGN_EN
    localparam bit GRID = 1'b1;
`else
    localparam bit GRID = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0, player_reset = 1'b0, draw_req = 1'b0, pos_ack = 1'b0;
    logic [NP*CW-1:0] start_x = '0, start_y = '0;
    logic [NP*SW-1:0] speed = '0;
    logic [NP-1:0] mov_x = '0, dir_x = '0, mov_y = '0, dir_y = '0;
    logic [NP*CW-1:0] live_x, live_y, live_x4, live_y4;
    logic pos_valid, busy, done, v4, b4, d4;
    logic [0:0] pos_id, id4;
    logic [CW-1:0] pos_x, pos_y, px4, py4;

    int m_x[NP], m_y[NP], q_x[NP], q_y[NP];
    int m_cnt4;
    int passed = 0, total = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sprite_position_engine #(.N_PLAYERS(NP), .MOVE_DIV(1)) u_dut (
        .clock(clk), .reset(reset), .player_reset(player_reset),
        .start_x(start_x), .start_y(start_y), .speed(speed),
        .mov_x(mov_x), .dir_x(dir_x), .mov_y(mov_y), .dir_y(dir_y),
        .live_x(live_x), .live_y(live_y), .draw_req(draw_req),
        .pos_valid(pos_valid), .pos_id(pos_id), .pos_x(pos_x), .pos_y(pos_y),
        .pos_ack(pos_ack), .busy(busy), .done(done)
    );

    sprite_position_engine #(.N_PLAYERS(NP), .MOVE_DIV(4)) u_div (
        .clock(clk), .reset(reset), .player_reset(player_reset),
        .start_x(start_x), .start_y(start_y), .speed(speed),
        .mov_x(mov_x), .dir_x(dir_x), .mov_y(mov_y), .dir_y(dir_y),
        .live_x(live_x4), .live_y(live_y4), .draw_req(draw_req),
        .pos_valid(v4), .pos_id(id4), .pos_x(px4), .pos_y(py4),
        .pos_ack(pos_ack), .busy(b4), .done(d4)
    );

    function automatic int clamp(int v, int lo, int hi);
        return v < lo ? lo : v > hi ? hi : v;
    endfunction

    function automatic int step(int pos, int spd, bit dir, int lo, int hi);
        return dir ? clamp(pos + spd, lo, hi) : clamp(pos - spd, lo, hi);
    endfunction

    function automatic bit go_x(int p, int y);
        return mov_x[p] && (!GRID || (y - MIN_Y) % TILE == 0);
    endfunction

    function automatic bit go_y(int p, int x, int y);
        return mov_y[p] && (!GRID || ((x - MIN_X) % TILE == 0 && !go_x(p, y)));
    endfunction

    // reference positions: m_* for the every-cycle engine, q_* for the divide-by-4 engine
    always @(posedge clk) begin
        if (reset) begin
            for (int p = 0; p < NP; p++) begin
                m_x[p] <= MIN_X; m_y[p] <= MIN_Y; q_x[p] <= MIN_X; q_y[p] <= MIN_Y;
            end
            m_cnt4 <= 0;
        end else begin
            m_cnt4 <= (m_cnt4 + 1) % 4;
            for (int p = 0; p < NP; p++) begin
                int spd;
                spd = int'(speed[p*SW +: SW]);
                if (player_reset) begin
                    m_x[p] <= clamp(int'(start_x[p*CW +: CW]), MIN_X, MAX_X);
                    m_y[p] <= clamp(int'(start_y[p*CW +: CW]), MIN_Y, MAX_Y);
                    q_x[p] <= clamp(int'(start_x[p*CW +: CW]), MIN_X, MAX_X);
                    q_y[p] <= clamp(int'(start_y[p*CW +: CW]), MIN_Y, MAX_Y);
                end else begin
                    if (go_x(p, m_y[p])) m_x[p] <= step(m_x[p], spd, dir_x[p], MIN_X, MAX_X);
                    if (go_y(p, m_x[p], m_y[p])) m_y[p] <= step(m_y[p], spd, dir_y[p], MIN_Y, MAX_Y);
                    if (m_cnt4 == 3 && go_x(p, q_y[p])) q_x[p] <= step(q_x[p], spd, dir_x[p], MIN_X, MAX_X);
                    if (m_cnt4 == 3 && go_y(p, q_x[p], q_y[p])) q_y[p] <= step(q_y[p], spd, dir_y[p], MIN_Y, MAX_Y);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < NP; p++) begin
                total++;
                if (live_x[p*CW +: CW] !== CW'(m_x[p]) || live_y[p*CW +: CW] !== CW'(m_y[p]) ||
                    live_x4[p*CW +: CW] !== CW'(q_x[p]) || live_y4[p*CW +: CW] !== CW'(q_y[p]))
                    $display("FAIL live_pos p%0d: got (%0d,%0d) div4 (%0d,%0d), expected (%0d,%0d) div4 (%0d,%0d)",
                             p, live_x[p*CW +: CW], live_y[p*CW +: CW], live_x4[p*CW +: CW], live_y4[p*CW +: CW],
                             m_x[p], m_y[p], q_x[p], q_y[p]);
                else passed++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [NP*CW-1:0] sx, input logic [NP*CW-1:0] sy);
        mov_x = '0; mov_y = '0;
        start_x = sx; start_y = sy;
        player_reset = 1'b1;
        cyc(1);
        player_reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        chk_en = 1'b1;
        reset = 1'b0;
        total++;
        if ({pos_valid, busy, done, pos_id, pos_x, pos_y} !== '0)
            $display("FAIL reset_outputs: got %h expected 0", {pos_valid, busy, done, pos_id, pos_x, pos_y});
        else passed++;
        total++;
        if (live_x !== {9'd72, 9'd72} || live_y !== {9'd32, 9'd32})
            $display("FAIL reset_live: got x=%h y=%h expected x=%h y=%h", live_x, live_y, {9'd72, 9'd72}, {9'd32, 9'd32});
        else passed++;
    endtask

    task automatic test_load_emit();
        speed = {5'd2, 5'd2};
        load({9'd500, 9'd10}, {9'd0, 9'd300});
        total++;
        if (live_x !== {9'd232, 9'd72} || live_y !== {9'd32, 9'd192})
            $display("FAIL load_clamp: got x=%h y=%h expected x=%h y=%h", live_x, live_y, {9'd232, 9'd72}, {9'd32, 9'd192});
        else passed++;
        load({9'd232, 9'd72}, {9'd96, 9'd96});
        draw_req = 1'b1; cyc(1); draw_req = 1'b0;
        total++;
        if ({pos_valid, busy, done, pos_id, pos_x, pos_y} !== {3'b110, 1'b0, 9'd72, 9'd96})
            $display("FAIL emit_id0: got %h expected %h", {pos_valid, busy, done, pos_id, pos_x, pos_y}, {3'b110, 1'b0, 9'd72, 9'd96});
        else passed++;
        pos_ack = 1'b1; cyc(1); pos_ack = 1'b0;
        total++;
        if ({pos_valid, busy, done, pos_id, pos_x, pos_y} !== {3'b110, 1'b1, 9'd232, 9'd96})
            $display("FAIL emit_id1: got %h expected %h", {pos_valid, busy, done, pos_id, pos_x, pos_y}, {3'b110, 1'b1, 9'd232, 9'd96});
        else passed++;
        pos_ack = 1'b1; cyc(1); pos_ack = 1'b0;
        total++;
        if ({pos_valid, busy, done} !== 3'b001)
            $display("FAIL done_pulse: got %b expected 001", {pos_valid, busy, done});
        else passed++;
        draw_req = 1'b1; cyc(1); draw_req = 1'b0;
        total++;
        if ({pos_valid, busy, done} !== 3'b000)
            $display("FAIL done_end_draw_ignored: got %b expected 000", {pos_valid, busy, done});
        else passed++;
        pos_ack = 1'b1; cyc(2); pos_ack = 1'b0;
        total++;
        if ({pos_valid, busy, done} !== 3'b000)
            $display("FAIL idle_ack_ignored: got %b expected 000", {pos_valid, busy, done});
        else passed++;
    endtask

    task automatic test_saturate();
        speed = {5'd2, 5'd5};
        load({9'd100, 9'd72}, {9'd96, 9'd96});
        dir_x = 2'b00; mov_x = 2'b01;
        cyc(3);
        mov_x = '0;
        total++;
        if (live_x[8:0] !== 9'd72) $display("FAIL sat_min: got %0d expected 72", live_x[8:0]);
        else passed++;
        load({9'd100, 9'd230}, {9'd96, 9'd96});
        dir_x = 2'b01; mov_x = 2'b01;
        cyc(1);
        total++;
        if (live_x[8:0] !== 9'd232) $display("FAIL sat_max: got %0d expected 232", live_x[8:0]);
        else passed++;
        cyc(3);
        mov_x = '0;
        total++;
        if (live_x[8:0] !== 9'd232) $display("FAIL sat_hold: got %0d expected 232", live_x[8:0]);
        else passed++;
    endtask

    task automatic test_divider();
        speed = {5'd2, 5'd2};
        load({9'd72, 9'd72}, {9'd96, 9'd96});
        for (int k = 0; k < 4 && m_cnt4 != 0; k++) cyc(1);
        dir_y = 2'b01; mov_y = 2'b01;
        cyc(8);
        mov_y = '0;
        total++;
        if (live_y4[8:0] !== 9'd100 || live_y[8:0] !== 9'd112)
            $display("FAIL divider: got div4 y=%0d div1 y=%0d expected 100 and 112", live_y4[8:0], live_y[8:0]);
        else passed++;
    endtask

    task automatic test_hold_snapshot();
        speed = {5'd2, 5'd2};
        load({9'd232, 9'd72}, {9'd96, 9'd96});
        draw_req = 1'b1; cyc(1); draw_req = 1'b0;
        dir_x = 2'b00; mov_x = 2'b10; draw_req = 1'b1;
        cyc(1);
        draw_req = 1'b0;
        cyc(4);
        mov_x = '0;
        total++;
        if (live_x[17:9] !== 9'd222) $display("FAIL hold_live: got %0d expected 222", live_x[17:9]);
        else passed++;
        total++;
        if ({pos_valid, busy, done, pos_id, pos_x, pos_y} !== {3'b110, 1'b0, 9'd72, 9'd96})
            $display("FAIL hold_id0: got %h expected %h", {pos_valid, busy, done, pos_id, pos_x, pos_y}, {3'b110, 1'b0, 9'd72, 9'd96});
        else passed++;
        pos_ack = 1'b1; cyc(1); pos_ack = 1'b0;
        total++;
        if ({pos_valid, pos_id, pos_x, pos_y} !== {1'b1, 1'b1, 9'd232, 9'd96})
            $display("FAIL hold_id1: got %h expected %h", {pos_valid, pos_id, pos_x, pos_y}, {1'b1, 1'b1, 9'd232, 9'd96});
        else passed++;
        pos_ack = 1'b1; cyc(1); pos_ack = 1'b0;
        cyc(1);
    endtask

    task automatic test_reset_mid();
        draw_req = 1'b1; cyc(1); draw_req = 1'b0;
        pos_ack = 1'b1; cyc(1); pos_ack = 1'b0;
        total++;
        if ({pos_valid, pos_id} !== 2'b11) $display("FAIL mid_pre: got %b expected 11", {pos_valid, pos_id});
        else passed++;
        reset = 1'b1; cyc(1); reset = 1'b0;
        total++;
        if ({pos_valid, busy, done} !== 3'b000) $display("FAIL mid_reset: got %b expected 000", {pos_valid, busy, done});
        else passed++;
        draw_req = 1'b1; cyc(1); draw_req = 1'b0;
        total++;
        if ({pos_valid, busy, done, pos_id, pos_x, pos_y} !== {3'b110, 1'b0, 9'd72, 9'd32})
            $display("FAIL mid_restart: got %h expected %h", {pos_valid, busy, done, pos_id, pos_x, pos_y}, {3'b110, 1'b0, 9'd72, 9'd32});
        else passed++;
        pos_ack = 1'b1; cyc(2); pos_ack = 1'b0;
        total++;
        if ({pos_valid, busy, done} !== 3'b001) $display("FAIL mid_done: got %b expected 001", {pos_valid, busy, done});
        else passed++;
        cyc(1);
    endtask

`ifdef GRID_ALIGN_EN
    task automatic test_grid();
        speed = {5'd2, 5'd2};
        dir_x = 2'b01; dir_y = 2'b01;
        load({9'd100, 9'd74}, {9'd96, 9'd96});
        mov_y = 2'b01; cyc(1); mov_y = '0;
        total++;
        if (live_y[8:0] !== 9'd96) $display("FAIL grid_blocked: got y=%0d expected 96", live_y[8:0]);
        else passed++;
        load({9'd100, 9'd88}, {9'd96, 9'd96});
        mov_y = 2'b01; cyc(1); mov_y = '0;
        total++;
        if (live_y[8:0] !== 9'd98) $display("FAIL grid_aligned: got y=%0d expected 98", live_y[8:0]);
        else passed++;
        load({9'd100, 9'd88}, {9'd96, 9'd96});
        mov_x = 2'b01; mov_y = 2'b01; cyc(1); mov_x = '0; mov_y = '0;
        total++;
        if (live_x[8:0] !== 9'd90 || live_y[8:0] !== 9'd96)
            $display("FAIL grid_x_first: got (%0d,%0d) expected (90,96)", live_x[8:0], live_y[8:0]);
        else passed++;
    endtask
`endif

    task automatic randomize_moves();
        mov_x = NP'($urandom); dir_x = NP'($urandom);
        mov_y = NP'($urandom); dir_y = NP'($urandom);
    endtask

    task automatic test_random();
        repeat (300) begin
            player_reset = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NP; p++) begin
                start_x[p*CW +: CW] = CW'($urandom_range(0, 511));
                start_y[p*CW +: CW] = CW'($urandom_range(0, 511));
                speed[p*SW +: SW] = SW'($urandom_range(0, 31));
            end
            randomize_moves();
            cyc(1);
        end
        player_reset = 1'b0;
        repeat (8) begin
            int sx[NP], sy[NP];
            for (int p = 0; p < NP; p++) begin
                sx[p] = m_x[p]; sy[p] = m_y[p];
            end
            draw_req = 1'b1; cyc(1); draw_req = 1'b0;
            for (int p = 0; p < NP; p++) begin
                int w;
                w = $urandom_range(0, 4);
                for (int k = 0; k <= w; k++) begin
                    randomize_moves();
                    player_reset = ($urandom_range(0, 7) == 0);
                    total++;
                    if ({pos_valid, busy, pos_id, pos_x, pos_y} !== {2'b11, 1'(p), CW'(sx[p]), CW'(sy[p])})
                        $display("FAIL rand_emit p%0d: got %h expected %h", p, {pos_valid, busy, pos_id, pos_x, pos_y},
                                 {2'b11, 1'(p), CW'(sx[p]), CW'(sy[p])});
                    else passed++;
                    pos_ack = (k == w);
                    cyc(1);
                end
                pos_ack = 1'b0;
            end
            player_reset = 1'b0;
            total++;
            if ({pos_valid, busy, done} !== 3'b001) $display("FAIL rand_done: got %b expected 001", {pos_valid, busy, done});
            else passed++;
            cyc(1);
        end
        mov_x = '0; mov_y = '0;
    endtask

    initial begin
        test_reset();
        test_load_emit();
        test_saturate();
        test_divider();
        test_hold_snapshot();
        test_reset_mid();
`ifdef GRID_ALIGN_EN
        test_grid();
`endif
        test_random();
        cyc(2);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
